vec_exec_unit: RTL and testbench
================================

Name: vec_exec_unit

Overview:
- Multi-cycle vector arithmetic engine of the vector coprocessor.
- Takes whole-register operands (VLEN bits, packed ELEMENT_WIDTH-bit elements) on a start pulse and computes an element-wise or reduction result selected by funct7.
- Returns the result with a one-cycle done pulse; the control FSM then writes the result to the vector register file.

Parameters:
- VLEN, 256, vector register width in bits.
- ELEMENT_WIDTH, 32, element width in bits; NUM_ELEM = VLEN/ELEMENT_WIDTH (8 by default). VLEN must be a multiple of ELEMENT_WIDTH.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle start pulse; operands valid in the same cycle.
- done_o  out  1  one-cycle completion pulse.
- funct7_i  in  7  operation select.
- funct3_i  in  3  reserved modifier; latched, no functional effect.
- vec_a_i  in  VLEN  operand A.
- vec_b_i  in  VLEN  operand B.
- vec_c_i  in  VLEN  accumulator operand C (VMAC only).
- result_o  out  VLEN  result, registered.
- vrf_rd_en_o  out  1  auxiliary VRF read enable; reserved, driven 0.
- vrf_rd_addr_o  out  5  auxiliary VRF read address; reserved, driven 0.
- vrf_rd_data_i  in  VLEN  auxiliary VRF read data; unused.

Behaviour:
- Opcodes (funct7): VADD 7'h01, VSUB 7'h02, VMUL 7'h03, VMAC 7'h04, VMMUL 7'h05. Any other value is unknown.
- Element i occupies bits [i*EW +: EW].
- All arithmetic is unsigned modulo 2^EW: wrap on overflow/underflow; multiply keeps the low EW bits of the product.
- Per-element results:
  - VADD: a+b.
  - VSUB: a-b.
  - VMUL: a*b.
  - VMAC: a*b+c.
  - VMMUL (dot product): element 0 = sum over i of a[i]*b[i], mod 2^EW; all other elements 0.
- States: IDLE, EXEC, REDUCE, DONE.
- IDLE:
  - On start_i, latch A, B, C, funct7, funct3.
  - Go to REDUCE if VMMUL, else EXEC.
  - start_i in any other state is ignored.
- EXEC:
  - Register the element-wise result (unknown funct7 gives all-zero result).
  - Go to DONE.
- REDUCE:
  - Accumulator cleared at the start edge.
  - One element per cycle: acc += a[k]*b[k], k = 0..NUM_ELEM-1.
  - After the last element, write result_o = {0..., acc}, go to DONE.
- DONE: done_o=1 for exactly this cycle, then IDLE. A start_i in the DONE cycle is ignored.
- Latency, start edge to done_o high:
  - Element-wise and unknown opcodes: 2 cycles (start cycle N, done cycle N+2).
  - VMMUL: NUM_ELEM+2 cycles (10 by default).
- result_o holds its value from the cycle done_o is asserted until the next operation's result is written.
- Operands may change after the start cycle without affecting the result.
- Reset: state IDLE, done_o=0, result_o=0, accumulator=0, vrf_rd_en_o=0, vrf_rd_addr_o=0.
- Reset asserted mid-operation aborts the operation: no done_o pulse, outputs return to reset values.

Test Plan:
- VADD, a all 32'hFFFFFFFF, b all 1 → result all 0 (wrap); done_o one cycle, 2 cycles after start.
- VSUB, a element i = i, b element i = 2i → element i = -i mod 2^32 (element 1 = 32'hFFFFFFFF).
- VMUL, a[i]=32'h0001_0000, b[i]=32'h0001_0001 → each element 32'h0001_0000 (low half kept); VMAC with c[i]=5 → each element 32'h0001_0005.
- VMMUL, a[i]=i+1, b[i]=2 → element 0 = 72, elements 1..7 = 0; done_o exactly 10 cycles after start; a second start_i during busy is ignored.
- funct7=7'h7F → result 0, done_o after 2 cycles; vrf_rd_en_o stays 0 in every test.
- Assert rst_ni low during a VMMUL (cycle 4) → no done_o pulse, result_o=0; a subsequent VADD completes normally.

Source files
------------

// File: rtl/vec_exec_unit.sv
// Multi-cycle vector arithmetic engine: element-wise add/sub/mul/mac in one
// execute cycle, or a serial dot-product reduction one element per cycle.
module vec_exec_unit #(
  parameter int unsigned VLEN          = 256,
  parameter int unsigned ELEMENT_WIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              done_o,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  input  logic [VLEN-1:0]   vec_a_i,
  input  logic [VLEN-1:0]   vec_b_i,
  input  logic [VLEN-1:0]   vec_c_i,
  output logic [VLEN-1:0]   result_o,
  output logic              vrf_rd_en_o,
  output logic [4:0]        vrf_rd_addr_o,
  input  logic [VLEN-1:0]   vrf_rd_data_i
);

  localparam int unsigned EW       = ELEMENT_WIDTH;
  localparam int unsigned NUM_ELEM = VLEN / EW;
  localparam int unsigned CW       = $clog2(NUM_ELEM + 1);

  localparam logic [6:0] OP_VADD  = 7'h01;
  localparam logic [6:0] OP_VSUB  = 7'h02;
  localparam logic [6:0] OP_VMUL  = 7'h03;
  localparam logic [6:0] OP_VMAC  = 7'h04;
  localparam logic [6:0] OP_VMMUL = 7'h05;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_REDUCE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [VLEN-1:0]   r_a;
  logic [VLEN-1:0]   r_b;
  logic [VLEN-1:0]   r_c;
  logic [6:0]        r_funct7;
  logic [2:0]        r_funct3;
  logic [EW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic [VLEN-1:0]   r_result;
  logic              r_done;

  logic [VLEN-1:0]   w_elem;
  logic [EW-1:0]     w_prod;
  logic              w_unused;

  always_comb begin
    w_elem = '0;
    for (int unsigned i = 0; i < NUM_ELEM; i++) begin
      case (r_funct7)
        OP_VADD: w_elem[i*EW +: EW] = r_a[i*EW +: EW] + r_b[i*EW +: EW];
        OP_VSUB: w_elem[i*EW +: EW] = r_a[i*EW +: EW] - r_b[i*EW +: EW];
        OP_VMUL: w_elem[i*EW +: EW] = r_a[i*EW +: EW] * r_b[i*EW +: EW];
        OP_VMAC: w_elem[i*EW +: EW] = r_a[i*EW +: EW] * r_b[i*EW +: EW]
                                      + r_c[i*EW +: EW];
        default: w_elem[i*EW +: EW] = '0;
      endcase
    end
  end

  // The reduction walks the latched operands by shifting them down one
  // element per cycle, so the current pair is always in the low element.
  assign w_prod = r_a[EW-1:0] * r_b[EW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_funct7 <= '0;
      r_funct3 <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a      <= vec_a_i;
            r_b      <= vec_b_i;
            r_c      <= vec_c_i;
            r_funct7 <= funct7_i;
            r_funct3 <= funct3_i;
            r_acc    <= '0;
            r_cnt    <= CW'(NUM_ELEM);
            r_state  <= (funct7_i == OP_VMMUL) ? S_REDUCE : S_EXEC;
          end
        end
        S_EXEC: begin
          r_result <= w_elem;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_REDUCE: begin
          // One extra cycle after the last element commits the sum.
          if (r_cnt == '0) begin
            r_result          <= '0;
            r_result[EW-1:0]  <= r_acc;
            r_done            <= 1'b1;
            r_state           <= S_DONE;
          end else begin
            r_acc <= r_acc + w_prod;
            r_a   <= r_a >> EW;
            r_b   <= r_b >> EW;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done_o        = r_done;
  assign result_o      = r_result;
  assign vrf_rd_en_o   = 1'b0;
  assign vrf_rd_addr_o = '0;
  assign w_unused      = ^{vrf_rd_data_i, r_funct3};

endmodule

// File: tb/tb_vec_exec_unit.sv
// Scoreboard bench for vec_exec_unit: expected result and latency are queued
// at start and compared when done_o is seen.
module tb_vec_exec_unit;

  localparam int VLEN = 256;
  localparam int EW   = 32;
  localparam int NE   = VLEN / EW;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            start_i;
  logic            done_o;
  logic [6:0]      funct7_i;
  logic [2:0]      funct3_i;
  logic [VLEN-1:0] vec_a_i;
  logic [VLEN-1:0] vec_b_i;
  logic [VLEN-1:0] vec_c_i;
  logic [VLEN-1:0] result_o;
  logic            vrf_rd_en_o;
  logic [4:0]      vrf_rd_addr_o;
  logic [VLEN-1:0] vrf_rd_data_i;

  always #5 clk = ~clk;

  vec_exec_unit #(
    .VLEN         (VLEN),
    .ELEMENT_WIDTH(EW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .done_o       (done_o),
    .funct7_i     (funct7_i),
    .funct3_i     (funct3_i),
    .vec_a_i      (vec_a_i),
    .vec_b_i      (vec_b_i),
    .vec_c_i      (vec_c_i),
    .result_o     (result_o),
    .vrf_rd_en_o  (vrf_rd_en_o),
    .vrf_rd_addr_o(vrf_rd_addr_o),
    .vrf_rd_data_i(vrf_rd_data_i)
  );

  logic [VLEN-1:0] exp_q[$];
  int              lat_q[$];
  int              n_chk  = 0;
  int              n_pass = 0;

  task automatic check(input string tag, input logic [VLEN-1:0] got,
                       input logic [VLEN-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [VLEN-1:0] fill(input logic [31:0] v);
    logic [VLEN-1:0] r;
    for (int i = 0; i < NE; i++) r[i*EW +: EW] = v;
    return r;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] r;
    for (int i = 0; i < NE; i++) r[i*EW +: EW] = $urandom;
    return r;
  endfunction

  function automatic logic [VLEN-1:0] model(input logic [6:0] f,
      input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
      input logic [VLEN-1:0] c);
    logic [VLEN-1:0] r;
    logic [31:0]     ea, eb, ec, acc, p;
    r   = '0;
    acc = 32'd0;
    for (int i = 0; i < NE; i++) begin
      ea = a[i*EW +: EW];
      eb = b[i*EW +: EW];
      ec = c[i*EW +: EW];
      p  = ea * eb;
      case (f)
        7'h01: r[i*EW +: EW] = ea + eb;
        7'h02: r[i*EW +: EW] = ea - eb;
        7'h03: r[i*EW +: EW] = p;
        7'h04: r[i*EW +: EW] = p + ec;
        7'h05: acc = acc + p;
        default: ;
      endcase
    end
    if (f == 7'h05) r[EW-1:0] = acc;
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [6:0] f,
      input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
      input logic [VLEN-1:0] c, input logic [VLEN-1:0] exp_res,
      input int exp_lat, input bit busy_start, input bit done_start);
    int              lat;
    bit              seen;
    bit              vrf_bad;
    bit              extra_done;
    logic [VLEN-1:0] e;
    int              el;
    @(negedge clk);
    funct7_i = f;
    funct3_i = 3'($urandom);
    vec_a_i  = a;
    vec_b_i  = b;
    vec_c_i  = c;
    start_i  = 1'b1;
    exp_q.push_back(exp_res);
    lat_q.push_back(exp_lat);
    lat     = 0;
    seen    = 1'b0;
    vrf_bad = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start_i  = 1'b0;
        funct7_i = 7'h01;
        vec_a_i  = rand_vec();
        vec_b_i  = rand_vec();
        vec_c_i  = rand_vec();
      end
      if (busy_start && lat == 3) start_i = 1'b1;
      if (busy_start && lat == 4) start_i = 1'b0;
      if (vrf_rd_en_o !== 1'b0 || vrf_rd_addr_o !== 5'd0) vrf_bad = 1'b1;
      if (done_o === 1'b1) seen = 1'b1;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    check({tag, "_done_seen"}, VLEN'(seen), VLEN'(1));
    check({tag, "_latency"}, VLEN'(lat), VLEN'(el));
    check({tag, "_result"}, result_o, e);
    check({tag, "_vrf_idle"}, VLEN'(vrf_bad), '0);
    if (done_start) begin
      start_i  = 1'b1;
      funct7_i = 7'h01;
      vec_a_i  = fill(32'd1);
      vec_b_i  = fill(32'd1);
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check({tag, "_pulse_1cyc"}, VLEN'(done_o), '0);
    check({tag, "_hold"}, result_o, e);
    if (done_start) begin
      extra_done = 1'b0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (done_o !== 1'b0) extra_done = 1'b1;
      end
      check({tag, "_done_start_ignored"}, VLEN'(extra_done), '0);
      check({tag, "_hold_after"}, result_o, e);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VLEN-1:0] a, b, c, e;
    logic [6:0]      f;
    bit              any_done;
    rst_ni        = 1'b0;
    start_i       = 1'b0;
    funct7_i      = '0;
    funct3_i      = '0;
    vec_a_i       = '0;
    vec_b_i       = '0;
    vec_c_i       = '0;
    vrf_rd_data_i = '1;
    repeat (2) @(negedge clk);
    check("rst_done", VLEN'(done_o), '0);
    check("rst_result", result_o, '0);
    check("rst_vrf", VLEN'({vrf_rd_en_o, vrf_rd_addr_o}), '0);
    rst_ni = 1'b1;
    @(negedge clk);

    run_op("vadd_wrap", 7'h01, fill(32'hFFFF_FFFF), fill(32'd1), '0,
           '0, 2, 1'b0, 1'b1);

    for (int i = 0; i < NE; i++) begin
      a[i*EW +: EW] = i;
      b[i*EW +: EW] = 2 * i;
      e[i*EW +: EW] = 32'(0 - i);
    end
    run_op("vsub_neg", 7'h02, a, b, '0, e, 2, 1'b0, 1'b0);

    run_op("vmul_low", 7'h03, fill(32'h0001_0000), fill(32'h0001_0001), '0,
           fill(32'h0001_0000), 2, 1'b0, 1'b0);
    run_op("vmac", 7'h04, fill(32'h0001_0000), fill(32'h0001_0001),
           fill(32'd5), fill(32'h0001_0005), 2, 1'b0, 1'b0);

    for (int i = 0; i < NE; i++) a[i*EW +: EW] = i + 1;
    e = '0;
    e[EW-1:0] = 32'd72;
    run_op("vmmul_dot", 7'h05, a, fill(32'd2), '0, e, 10, 1'b1, 1'b0);

    run_op("unknown_op", 7'h7F, rand_vec(), rand_vec(), rand_vec(),
           '0, 2, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      case (k)
        0: f = 7'h01;
        1: f = 7'h02;
        2: f = 7'h03;
        3: f = 7'h04;
        4: f = 7'h05;
        default: f = 7'h40;
      endcase
      a = rand_vec();
      b = rand_vec();
      c = rand_vec();
      run_op("rand_op", f, a, b, c, model(f, a, b, c),
             (f == 7'h05) ? 10 : 2, 1'b0, 1'b0);
    end

    run_op("vmac_pre_rst", 7'h04, fill(32'd3), fill(32'd4), fill(32'd1),
           fill(32'd13), 2, 1'b0, 1'b0);

    @(negedge clk);
    funct7_i = 7'h05;
    vec_a_i  = fill(32'd7);
    vec_b_i  = fill(32'd9);
    start_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_result", result_o, '0);
    check("midrst_done", VLEN'(done_o), '0);
    repeat (2) @(negedge clk);
    rst_ni   = 1'b1;
    any_done = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (done_o !== 1'b0) any_done = 1'b1;
    end
    check("midrst_no_done", VLEN'(any_done), '0);
    check("midrst_result_stays", result_o, '0);

    run_op("vadd_after_rst", 7'h01, fill(32'd10), fill(32'd20), '0,
           fill(32'd30), 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
